vend_sequencer: RTL and testbench
=================================

Name: vend_sequencer

Overview:
- Multi-item vending controller that sequences a shared item dispenser and a shared 5-unit change ejector.
- Accumulates coin credit and checks the selection's price and stock.
- Drives a req/ack handshake to the dispenser, then pays out remaining credit one coin at a time.
- Sits between the coin acceptor front end and the dispenser/change mechanics; replaces per-transaction FSM logic with a credit-based scheduler.

Parameters:
- N_ITEMS, 4, number of selectable items (item index width = clog2(N_ITEMS)).
- CREDIT_W, 5, credit register width, in units of 5.
- CREDIT_MAX, 20, maximum credit in units (100).
- STOCK_W, 4, per-item stock counter width.
- STOCK_INIT, 8, stock loaded into every item on reset.
- DISP_TIMEOUT, 64, cycles to wait for disp_ack before declaring a fault.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in  in  2  coin event, one-cycle pulse per coin: 01 = 5, 10 = 10, 00 = none, 11 = invalid (ignored, no reject)
- sel_valid  in  1  selection strobe
- sel_item  in  clog2(N_ITEMS)  selected item index
- cancel  in  1  refund request
- disp_req  out  1  dispense request to shared dispenser
- disp_item  out  clog2(N_ITEMS)  item to dispense; stable while disp_req is high
- disp_ack  in  1  dispenser completion
- chg_ready  in  1  change ejector can accept a coin
- chg_pulse  out  1  eject one 5-unit coin
- credit  out  CREDIT_W  current credit in units
- vend_done  out  1  one-cycle pulse: item dispensed
- coin_reject  out  1  one-cycle pulse: coin not accepted
- sold_out  out  1  one-cycle pulse: selected stock is zero
- need_more  out  1  one-cycle pulse: credit below price
- disp_fault  out  1  one-cycle pulse: dispenser timeout

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: all outputs registered and 0; credit = 0; every stock = STOCK_INIT; state = IDLE; timeout counter = 0.
- Prices come from a package table in units: item0 = 3, item1 = 4, item2 = 5, item3 = 2. Index >= N_ITEMS counts as sold_out.
- States: IDLE, VEND, CHANGE, GAP.
- IDLE, coins: credit += 1 or 2. If the sum would exceed CREDIT_MAX, pulse coin_reject and leave credit unchanged.
- IDLE, priority of the other inputs: cancel > sel_valid.
- IDLE, cancel: with credit > 0, go to CHANGE; with credit == 0, no effect.
- IDLE, sel_valid: evaluated against credit as registered at the start of the cycle; a coin in the same cycle is still added.
  - stock == 0: pulse sold_out.
  - credit < price: pulse need_more.
  - Otherwise: credit -= price (plus any same-cycle coin), stock--, latch item, go to VEND with disp_req = 1 from the next cycle.
- VEND:
  - disp_req is held high and disp_item is stable.
  - On the cycle disp_ack is sampled high: next cycle disp_req = 0 and vend_done = 1 (one cycle); go to CHANGE if credit > 0, else IDLE.
  - If the timeout counter reaches DISP_TIMEOUT without ack: drop disp_req, pulse disp_fault, restore credit += price and stock++, go to CHANGE.
- CHANGE:
  - credit == 0: go to IDLE.
  - chg_ready high: chg_pulse = 1 for one cycle, credit -= 1, go to GAP.
  - GAP lasts exactly one cycle and returns to CHANGE, so pulses are never back-to-back.
  - chg_ready low: wait, no timeout.
- In VEND, CHANGE and GAP: every valid coin pulses coin_reject; sel_valid and cancel are ignored.
- Simultaneous disp_ack and timeout expiry in the same cycle: ack wins (no fault).
- rst during any state aborts immediately: disp_req and chg_pulse drop on the next edge; credit is lost and stock reloads (documented; no pending refund).
- Arithmetic: credit is unsigned and never wraps; stock never decrements below 0.

Decomposition:
- Package vend_pkg holds:
  - coin encodings (COIN_5 = 2'b01, COIN_10 = 2'b10)
  - state enum
  - PRICE table function price_of(item)
- Sub-module vend_stock_bank holds the N_ITEMS stock counters, with:
  - read port: item → stock
  - decrement strobe
  - restore strobe
  - synchronous reset to STOCK_INIT

Test Plan:
- Coins 10, 5 (credit 3); select item0 → disp_req = 1, disp_item = 0; ack after 4 cycles → vend_done, credit 0, return to IDLE, no chg_pulse.
- Coins 10, 10, 10 (credit 6); select item1 (price 4) → vend; after ack, exactly 2 chg_pulse, separated by ≥ 1 idle cycle; credit ends 0.
- Credit 2; select item2 → need_more pulse, credit stays 2. cancel → 2 chg_pulse. With chg_ready held low for 5 cycles mid-payout, pulses pause and then resume.
- Vend item3 eight times → ninth selection gives sold_out; credit unchanged.
- Credit 19; coin 10 → coin_reject, credit stays 19. Coin during VEND → coin_reject.
- Credit 3; select item0, hold disp_ack low → disp_fault after DISP_TIMEOUT cycles, credit restored to 3 and paid out as 3 pulses, stock0 back to 8. Repeat with rst asserted during VEND → all outputs 0 next cycle.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared encodings, state type and price table for the vending sequencer.
package vend_pkg;

  localparam logic [1:0] COIN_5  = 2'b01;
  localparam logic [1:0] COIN_10 = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_VEND,
    S_CHANGE,
    S_GAP
  } vend_state_e;

  function automatic int item_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Prices in 5-unit credits; unknown items price at 0 but always read as sold out.
  function automatic logic [7:0] price_of(input logic [7:0] item);
    case (item)
      8'd0:    return 8'd3;
      8'd1:    return 8'd4;
      8'd2:    return 8'd5;
      8'd3:    return 8'd2;
      default: return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_sequencer_if.sv
// Coin/selection front end plus dispenser and change-ejector handshakes.
interface vend_if
  import vend_pkg::*;
#(
  parameter int N_ITEMS  = 4,
  parameter int CREDIT_W = 5
);
  localparam int IW = item_w(N_ITEMS);

  logic [1:0]          in;
  logic                sel_valid;
  logic [IW-1:0]       sel_item;
  logic                cancel;
  logic                disp_req;
  logic [IW-1:0]       disp_item;
  logic                disp_ack;
  logic                chg_ready;
  logic                chg_pulse;
  logic [CREDIT_W-1:0] credit;
  logic                vend_done;
  logic                coin_reject;
  logic                sold_out;
  logic                need_more;
  logic                disp_fault;

  modport master (
    output in, sel_valid, sel_item, cancel, disp_ack, chg_ready,
    input  disp_req, disp_item, chg_pulse, credit, vend_done, coin_reject,
           sold_out, need_more, disp_fault
  );

  modport slave (
    input  in, sel_valid, sel_item, cancel, disp_ack, chg_ready,
    output disp_req, disp_item, chg_pulse, credit, vend_done, coin_reject,
           sold_out, need_more, disp_fault
  );

endinterface

// File: rtl/vend_stock_bank.sv
// Per-item stock counters; address space is padded to a power of two with empty slots.
module vend_stock_bank
  import vend_pkg::*;
#(
  parameter int N_ITEMS    = 4,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 8,
  parameter int IW         = item_w(N_ITEMS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IW-1:0]      rd_item,
  output logic [STOCK_W-1:0] rd_stock,
  input  logic               dec,
  input  logic               inc,
  input  logic [IW-1:0]      inc_item
);
  localparam int NS = 1 << IW;

  logic [NS-1:0][STOCK_W-1:0] stock;

  for (genvar i = 0; i < NS; i++) begin : g_slot
    if (i < N_ITEMS) begin : g_real
      logic [STOCK_W-1:0] cnt;
      always_ff @(posedge clk) begin
        if (rst)
          cnt <= STOCK_W'(STOCK_INIT);
        else if (dec && rd_item == IW'(i) && cnt != '0)
          cnt <= cnt - STOCK_W'(1);
        else if (inc && inc_item == IW'(i) && cnt != '1)
          cnt <= cnt + STOCK_W'(1);
      end
      assign stock[i] = cnt;
    end else begin : g_empty
      assign stock[i] = '0;
    end
  end

  assign rd_stock = stock[rd_item];

endmodule

// File: rtl/vend_sequencer.sv
// Credit-based vending scheduler: accept coins, vend via req/ack, then pay change one coin at a time.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int N_ITEMS      = 4,
  parameter int CREDIT_W     = 5,
  parameter int CREDIT_MAX   = 20,
  parameter int STOCK_W      = 4,
  parameter int STOCK_INIT   = 8,
  parameter int DISP_TIMEOUT = 64
) (
  input logic clk,
  input logic rst,
  vend_if.slave bus
);
  localparam int IW = item_w(N_ITEMS);
  localparam int TW = $clog2(DISP_TIMEOUT + 1);

  vend_state_e         state;
  logic [CREDIT_W-1:0] credit_q;
  logic [IW-1:0]       item_q;
  logic [TW-1:0]       tcnt;
  logic [STOCK_W-1:0]  rd_stock;
  logic [1:0]          coin_add;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fit, sel_ok, fault;
  logic [CREDIT_W-1:0] sel_price, item_price;

  always_comb begin
    coin_add = 2'd0;
    case (bus.in)
      COIN_5:  coin_add = 2'd1;
      COIN_10: coin_add = 2'd2;
      default: coin_add = 2'd0;
    endcase
  end

  assign coin_sum   = {1'b0, credit_q} + (CREDIT_W+1)'(coin_add);
  assign coin_fit   = (coin_add != 2'd0) && (coin_sum <= (CREDIT_W+1)'(CREDIT_MAX));
  assign sel_price  = CREDIT_W'(price_of(8'(bus.sel_item)));
  assign item_price = CREDIT_W'(price_of(8'(item_q)));
  // Selection is judged on start-of-cycle credit; cancel always shadows it.
  assign sel_ok = (state == S_IDLE) && !bus.cancel && bus.sel_valid &&
                  (rd_stock != '0) && (credit_q >= sel_price);
  // Ack in the expiry cycle wins, so the fault only fires without ack.
  assign fault  = (state == S_VEND) && !bus.disp_ack && (tcnt == TW'(DISP_TIMEOUT - 1));

  vend_stock_bank #(
    .N_ITEMS(N_ITEMS), .STOCK_W(STOCK_W), .STOCK_INIT(STOCK_INIT)
  ) u_stock (
    .clk(clk), .rst(rst),
    .rd_item(bus.sel_item), .rd_stock(rd_stock),
    .dec(sel_ok), .inc(fault), .inc_item(item_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      credit_q        <= '0;
      item_q          <= '0;
      tcnt            <= '0;
      bus.disp_req    <= 1'b0;
      bus.chg_pulse   <= 1'b0;
      bus.vend_done   <= 1'b0;
      bus.coin_reject <= 1'b0;
      bus.sold_out    <= 1'b0;
      bus.need_more   <= 1'b0;
      bus.disp_fault  <= 1'b0;
    end else begin
      bus.chg_pulse   <= 1'b0;
      bus.vend_done   <= 1'b0;
      bus.sold_out    <= 1'b0;
      bus.need_more   <= 1'b0;
      bus.disp_fault  <= 1'b0;
      bus.coin_reject <= (coin_add != 2'd0) && ((state != S_IDLE) || !coin_fit);
      case (state)
        S_IDLE: begin
          credit_q <= credit_q + (coin_fit ? CREDIT_W'(coin_add) : '0)
                               - (sel_ok ? sel_price : '0);
          if (bus.cancel) begin
            if (credit_q != '0) state <= S_CHANGE;
          end else if (bus.sel_valid) begin
            if (rd_stock == '0)
              bus.sold_out <= 1'b1;
            else if (credit_q < sel_price)
              bus.need_more <= 1'b1;
            else begin
              state        <= S_VEND;
              item_q       <= bus.sel_item;
              tcnt         <= '0;
              bus.disp_req <= 1'b1;
            end
          end
        end
        S_VEND: begin
          if (bus.disp_ack) begin
            bus.disp_req  <= 1'b0;
            bus.vend_done <= 1'b1;
            state         <= (credit_q != '0) ? S_CHANGE : S_IDLE;
          end else if (fault) begin
            bus.disp_req   <= 1'b0;
            bus.disp_fault <= 1'b1;
            credit_q       <= credit_q + item_price;
            state          <= S_CHANGE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_CHANGE: begin
          if (credit_q == '0)
            state <= S_IDLE;
          else if (bus.chg_ready) begin
            bus.chg_pulse <= 1'b1;
            credit_q      <= credit_q - CREDIT_W'(1);
            state         <= S_GAP;
          end
        end
        S_GAP:   state <= S_CHANGE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.disp_item = item_q;
  assign bus.credit    = credit_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed scenarios then random traffic, every cycle compared against a transaction-level model.
module tb_vend_sequencer;
  localparam int NI = 4, CW = 5, CMAX = 20, SI = 8, TO = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vend_if #(.N_ITEMS(NI), .CREDIT_W(CW)) bus ();

  vend_sequencer #(
    .N_ITEMS(NI), .CREDIT_W(CW), .CREDIT_MAX(CMAX),
    .STOCK_W(4), .STOCK_INIT(SI), .DISP_TIMEOUT(TO)
  ) u_dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // model: mode 0 = accepting, 1 = waiting on dispenser, 2 = paying out
  int price_t [NI] = '{3, 4, 5, 2};
  int m_credit, m_item, m_mode, m_wait, m_cool;
  int m_stock [NI];
  bit e_req, e_done, e_rej, e_so, e_nm, e_flt, e_chg;
  int n_pulse, n_b2b, n_done;
  bit prev_pulse, ack_block;

  task automatic model_step();
    int coin, add, si;
    {e_done, e_rej, e_so, e_nm, e_flt, e_chg} = '0;
    if (rst) begin
      m_credit = 0; m_item = 0; m_mode = 0; e_req = 0;
      foreach (m_stock[i]) m_stock[i] = SI;
      return;
    end
    coin = (bus.in == 2'b01) ? 1 : (bus.in == 2'b10) ? 2 : 0;
    si   = int'(bus.sel_item);
    if (m_mode == 0) begin
      add = 0;
      if (coin > 0) begin
        if (m_credit + coin > CMAX) e_rej = 1;
        else add = coin;
      end
      if (bus.cancel) begin
        if (m_credit > 0) begin m_mode = 2; m_cool = 0; end
      end else if (bus.sel_valid) begin
        if (si >= NI || m_stock[si] == 0) e_so = 1;
        else if (m_credit < price_t[si]) e_nm = 1;
        else begin
          m_credit -= price_t[si];
          m_stock[si]--;
          m_item = si; m_mode = 1; m_wait = 0; e_req = 1;
        end
      end
      m_credit += add;
    end else begin
      if (coin > 0) e_rej = 1;
      if (m_mode == 1) begin
        if (bus.disp_ack) begin
          e_req = 0; e_done = 1; m_cool = 0;
          m_mode = (m_credit > 0) ? 2 : 0;
        end else begin
          m_wait++;
          if (m_wait == TO) begin
            e_req = 0; e_flt = 1; m_cool = 0; m_mode = 2;
            m_credit += price_t[m_item];
            m_stock[m_item]++;
          end
        end
      end else begin
        if (m_cool > 0) m_cool--;
        else if (m_credit == 0) m_mode = 0;
        else if (bus.chg_ready) begin e_chg = 1; m_credit--; m_cool = 1; end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("disp_req",    bus.disp_req,    e_req);
    chk("disp_item",   bus.disp_item,   m_item);
    chk("credit",      bus.credit,      m_credit);
    chk("vend_done",   bus.vend_done,   e_done);
    chk("coin_reject", bus.coin_reject, e_rej);
    chk("sold_out",    bus.sold_out,    e_so);
    chk("need_more",   bus.need_more,   e_nm);
    chk("disp_fault",  bus.disp_fault,  e_flt);
    chk("chg_pulse",   bus.chg_pulse,   e_chg);
    if (bus.chg_pulse) begin
      n_pulse++;
      if (prev_pulse) n_b2b++;
    end
    prev_pulse = bus.chg_pulse;
    if (bus.vend_done) n_done++;
  endtask

  task automatic coin(input logic [1:0] c);
    bus.in = c; cyc(); bus.in = 2'b00;
  endtask

  task automatic sel(input int it);
    logic [1:0] v;
    v = 2'(it);
    bus.sel_item = v; bus.sel_valid = 1'b1; cyc(); bus.sel_valid = 1'b0;
  endtask

  task automatic ack();
    bus.disp_ack = 1'b1; cyc(); bus.disp_ack = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_mode != 0 && n < 400) begin cyc(); n++; end
    chk("idle_bound", m_mode, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); rst = 1'b0;
  endtask

  initial begin
    int cnt, p, r;
    bus.in = 2'b00; bus.sel_valid = 1'b0; bus.sel_item = '0; bus.cancel = 1'b0;
    bus.disp_ack = 1'b0; bus.chg_ready = 1'b1; rst = 1'b1;
    cyc(); cyc(); rst = 1'b0;
    chk("rst_credit", bus.credit, 0);
    chk("rst_req", bus.disp_req, 0);

    // exact-credit vend, no change
    coin(2'b10); coin(2'b01);
    chk("t1_credit", bus.credit, 3);
    n_pulse = 0;
    sel(0);
    chk("t1_req", bus.disp_req, 1);
    chk("t1_item", bus.disp_item, 0);
    repeat (3) cyc();
    ack();
    chk("t1_done", bus.vend_done, 1);
    wait_idle();
    chk("t1_pulses", n_pulse, 0);
    chk("t1_credit_end", bus.credit, 0);

    // vend with two coins of change
    repeat (3) coin(2'b10);
    chk("t2_credit", bus.credit, 6);
    n_pulse = 0; n_b2b = 0;
    sel(1); repeat (2) cyc(); ack(); wait_idle();
    chk("t2_pulses", n_pulse, 2);
    chk("t2_b2b", n_b2b, 0);
    chk("t2_credit_end", bus.credit, 0);

    // short credit, refund with a stalled ejector
    coin(2'b10);
    sel(2);
    chk("t3_need_more", bus.need_more, 1);
    chk("t3_credit", bus.credit, 2);
    n_pulse = 0;
    bus.cancel = 1'b1; cyc(); bus.cancel = 1'b0;
    for (int k = 0; k < 20 && n_pulse == 0; k++) cyc();
    bus.chg_ready = 1'b0;
    p = n_pulse;
    repeat (5) cyc();
    chk("t3_pause", n_pulse, p);
    bus.chg_ready = 1'b1;
    wait_idle();
    chk("t3_pulses", n_pulse, 2);

    // drain item3
    n_done = 0;
    for (int k = 0; k < SI; k++) begin
      coin(2'b10); sel(3); cyc(); ack(); wait_idle();
    end
    chk("t4_vends", n_done, SI);
    coin(2'b10); sel(3);
    chk("t4_sold_out", bus.sold_out, 1);
    chk("t4_credit", bus.credit, 2);
    bus.cancel = 1'b1; cyc(); bus.cancel = 1'b0; wait_idle();

    // credit ceiling and coins while busy
    repeat (9) coin(2'b10);
    coin(2'b01);
    chk("t5_credit19", bus.credit, 19);
    coin(2'b10);
    chk("t5_reject_max", bus.coin_reject, 1);
    chk("t5_credit_hold", bus.credit, 19);
    coin(2'b01);
    chk("t5_credit20", bus.credit, 20);
    sel(0);
    coin(2'b01);
    chk("t5_reject_vend", bus.coin_reject, 1);
    ack(); wait_idle();

    // dispenser timeout restores credit and stock
    do_reset();
    coin(2'b10); coin(2'b01);
    sel(0);
    cnt = 0;
    do begin cyc(); cnt++; end while (!bus.disp_fault && cnt < 100);
    chk("t6_timeout", cnt, TO);
    chk("t6_credit", bus.credit, 3);
    chk("t6_stock0", u_dut.u_stock.stock[0], SI);
    n_pulse = 0;
    wait_idle();
    chk("t6_pulses", n_pulse, 3);

    // reset in the middle of a vend
    coin(2'b10); coin(2'b01); sel(0); repeat (5) cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("t7_req", bus.disp_req, 0);
    chk("t7_chg", bus.chg_pulse, 0);
    chk("t7_credit", bus.credit, 0);
    chk("t7_stock0", u_dut.u_stock.stock[0], SI);

    // random traffic
    ack_block = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 99);
      bus.in = (r < 15) ? 2'b01 : (r < 28) ? 2'b10 : (r < 31) ? 2'b11 : 2'b00;
      bus.sel_valid = ($urandom_range(0, 99) < 15);
      bus.sel_item  = 2'($urandom_range(0, 3));
      bus.cancel    = ($urandom_range(0, 99) < 4) && (m_credit > 0 || !bus.sel_valid);
      if (k % 250 == 0) ack_block = ($urandom_range(0, 3) == 0);
      bus.disp_ack  = !ack_block && ($urandom_range(0, 4) == 0);
      bus.chg_ready = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 599) == 0);
      cyc();
    end
    rst = 1'b0; bus.in = 2'b00; bus.sel_valid = 1'b0; bus.cancel = 1'b0;
    bus.disp_ack = 1'b0; bus.chg_ready = 1'b1;
    cyc();
    for (int i = 0; i < NI; i++) chk("stock_end", u_dut.u_stock.stock[i], m_stock[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
